nespad_poll_ctrl: RTL and testbench

//  Sequences the SNES pad reader for the MU: issues frame pulses on a programmable interval or on demand,

---
 rtl/nespad_pkg.sv | 25 ++
 rtl/nespad_interval_timer.sv | 37 +++
 rtl/nespad_poll_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_nespad_poll_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nespad_pkg.sv
// Shared constants for the SNES pad poll controller: register map, bit positions, FSM encoding.
package nespad_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_INTERVAL = 2'd1;
  localparam logic [1:0] ADDR_STATE    = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int CTRL_AUTO_EN = 0;
  localparam int CTRL_TRIGGER = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_TIMEOUT  = 1;
  localparam int STAT_VALID    = 2;
  localparam int STAT_POLL_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2,
    ST_CAPT = 2'd3
  } nespad_state_e;

endpackage

// File: rtl/nespad_interval_timer.sv
// Auto-poll interval down-counter: reloads on request or while disabled, ticks when it reaches 1.
module nespad_interval_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             reload_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (reload_i || !en_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q <= CNT_W'(1)) begin
      // a zero count while enabled can only follow a reload glitch; just reload silently
      tick_o = (cnt_q == CNT_W'(1));
      cnt_d  = load_val_i;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nespad_poll_ctrl.sv
// SNES pad poll sequencer with MU register interface.
// Optional change interrupt is built only when NESPAD_IRQ_EN is defined.
//   state | meaning
//   IDLE  | waiting for a pending poll request
//   FIRE  | one-cycle frame pulse to the reader
//   WAIT  | waiting for reader done edge or timeout
//   CAPT  | latch buttons and pressed edges
module nespad_poll_ctrl
  import nespad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int CNT_W          = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_start_i,
  input  logic        bus_we_i,
  input  logic [1:0]  bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic [31:0] bus_rdata_o,
  output logic        bus_done_o,
  output logic        pad_frame_o,
  input  logic        pad_done_i,
  input  logic [15:0] pad_state_i,
  output logic        irq_o
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  nespad_state_e    state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             auto_en_q, auto_en_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic [15:0]      buttons_q, buttons_d;
  logic [15:0]      pressed_q, pressed_d;
  logic             timeout_q, timeout_d;
  logic             valid_q, valid_d;
  logic [7:0]       poll_cnt_q, poll_cnt_d;
  logic             pend_q, pend_d;
  logic             done_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             bus_done_q;
  logic             irq_en_rd;

  logic wr, rd, wr_ctrl, wr_int, wr_stat, rd_state;
  logic done_rise, busy, tick, pend_clr, capt, to_evt;
  logic [31:0] rdata_mux;
  logic unused_wdata;

  assign wr       = bus_start_i & bus_we_i;
  assign rd       = bus_start_i & ~bus_we_i;
  assign wr_ctrl  = wr && (bus_addr_i == ADDR_CTRL);
  assign wr_int   = wr && (bus_addr_i == ADDR_INTERVAL);
  assign wr_stat  = wr && (bus_addr_i == ADDR_STATUS);
  assign rd_state = rd && (bus_addr_i == ADDR_STATE);

  assign done_rise    = pad_done_i & ~done_q;
  assign busy         = (state_q != ST_IDLE);
  assign pad_frame_o  = (state_q == ST_FIRE);
  assign unused_wdata = ^bus_wdata_i;

  nespad_interval_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (auto_en_q && (interval_q != '0)),
    .reload_i   (wr_ctrl | wr_int),
    .load_val_i (interval_d),
    .tick_o     (tick)
  );

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    pend_clr = 1'b0;
    capt     = 1'b0;
    to_evt   = 1'b0;
    case (state_q)
      ST_IDLE: if (pend_q) state_d = ST_FIRE;
      ST_FIRE: begin
        pend_clr = 1'b1;
        to_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise) begin
          state_d = ST_CAPT;
        end else if (to_cnt_q == TO_LAST) begin
          to_evt  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_CAPT: begin
        capt    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_mux = '0;
    case (bus_addr_i)
      ADDR_CTRL: begin
        rdata_mux[CTRL_AUTO_EN] = auto_en_q;
        rdata_mux[CTRL_IRQ_EN]  = irq_en_rd;
      end
      ADDR_INTERVAL: rdata_mux = 32'(interval_q);
      ADDR_STATE:    rdata_mux = {pressed_q, buttons_q};
      default: begin
        rdata_mux[STAT_BUSY]                      = busy;
        rdata_mux[STAT_TIMEOUT]                   = timeout_q;
        rdata_mux[STAT_VALID]                     = valid_q;
        rdata_mux[STAT_POLL_LSB +: 8]             = poll_cnt_q;
      end
    endcase
  end

  always_comb begin
    auto_en_d  = wr_ctrl ? bus_wdata_i[CTRL_AUTO_EN] : auto_en_q;
    interval_d = wr_int ? bus_wdata_i[CNT_W-1:0] : interval_q;
    pend_d     = (pend_q & ~pend_clr) | tick | (wr_ctrl & bus_wdata_i[CTRL_TRIGGER]);
    buttons_d  = buttons_q;
    valid_d    = valid_q;
    poll_cnt_d = poll_cnt_q;
    // the read clears old edges first so edges found by a same-cycle capture survive
    pressed_d  = rd_state ? 16'h0000 : pressed_q;
    if (capt) begin
      buttons_d  = ~pad_state_i;
      pressed_d  = pressed_d | (~pad_state_i & ~buttons_q);
      valid_d    = 1'b1;
      poll_cnt_d = poll_cnt_q + 8'd1;
    end
    timeout_d = timeout_q;
    if (wr_stat && bus_wdata_i[STAT_TIMEOUT]) timeout_d = 1'b0;
    if (to_evt) timeout_d = 1'b1;
    rdata_d = rd ? rdata_mux : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      to_cnt_q   <= '0;
      auto_en_q  <= 1'b0;
      interval_q <= '0;
      buttons_q  <= '0;
      pressed_q  <= '0;
      timeout_q  <= 1'b0;
      valid_q    <= 1'b0;
      poll_cnt_q <= '0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      bus_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      auto_en_q  <= auto_en_d;
      interval_q <= interval_d;
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      timeout_q  <= timeout_d;
      valid_q    <= valid_d;
      poll_cnt_q <= poll_cnt_d;
      pend_q     <= pend_d;
      done_q     <= pad_done_i;
      rdata_q    <= rdata_d;
      bus_done_q <= bus_start_i;
    end
  end

  assign bus_rdata_o = rdata_q;
  assign bus_done_o  = bus_done_q;

`ifdef NESPAD_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q;

  assign irq_en_d  = wr_ctrl ? bus_wdata_i[CTRL_IRQ_EN] : irq_en_q;
  assign irq_en_rd = irq_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_q && (pressed_q != 16'h0000);
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_en_rd = 1'b0;
  assign irq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_nespad_poll_ctrl.sv
// Directed bench for nespad_poll_ctrl with a behavioural pad reader (done 1100 clk after frame, held 32).
module tb_nespad_poll_ctrl;

`ifdef NESPAD_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_start = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        bus_done;
  logic        pad_frame;
  logic        pad_done;
  logic [15:0] pad_state = 16'hFFFF;
  logic        irq;

  always #5 clk = ~clk;

  nespad_poll_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_start_i (bus_start),
    .bus_we_i    (bus_we),
    .bus_addr_i  (bus_addr),
    .bus_wdata_i (bus_wdata),
    .bus_rdata_o (bus_rdata),
    .bus_done_o  (bus_done),
    .pad_frame_o (pad_frame),
    .pad_done_i  (pad_done),
    .pad_state_i (pad_state),
    .irq_o       (irq)
  );

  int checks = 0;
  int errors = 0;

  // reader model
  int delay_cnt, hold_cnt;
  bit model_mute = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_done  <= 1'b0;
      delay_cnt <= 0;
      hold_cnt  <= 0;
    end else begin
      if (pad_frame && !model_mute) delay_cnt <= 1100;
      else if (delay_cnt > 0) delay_cnt <= delay_cnt - 1;
      if (delay_cnt == 1) begin
        pad_done <= 1'b1;
        hold_cnt <= 32;
      end else if (hold_cnt > 1) begin
        hold_cnt <= hold_cnt - 1;
      end else begin
        pad_done <= 1'b0;
        hold_cnt <= 0;
      end
    end
  end

  // cycle counter, frame counter and overlap monitor
  int cyc = 0;
  int frames = 0;
  int overlap_err = 0;
  bit outstanding = 1'b0;
  bit mon_en = 1'b0;
  logic done_prev = 1'b0;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    done_prev <= pad_done;
    if (pad_frame) begin
      frames <= frames + 1;
      if (mon_en && outstanding) overlap_err <= overlap_err + 1;
      outstanding <= 1'b1;
    end else if (pad_done && !done_prev) begin
      outstanding <= 1'b0;
    end
    if (!rst_n) outstanding <= 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    @(posedge clk); #1;
    bus_start = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    @(posedge clk); #1;
    bus_start = 1'b0; bus_we = 1'b0;
    check("bus_done", {31'b0, bus_done}, 32'h1);
    rd = bus_rdata;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_frame(input int budget, output int fcyc);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!pad_frame && n < budget);
    check("frame_seen", {31'b0, pad_frame}, 32'h1);
    fcyc = cyc;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] st;
    int n = 0;
    do begin
      bus(1'b0, 2'd3, 32'h0, st);
      n += 2;
    end while (st[0] && n < budget);
    check("idle_reached", {31'b0, st[0]}, 32'h0);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] rd;
    int f1, f2, f3, base_frames, n;
    int base_poll;

    vecs = '{
      '{1'b0, 2'd0, 32'h0,        32'h0},
      '{1'b0, 2'd1, 32'h0,        32'h0},
      '{1'b0, 2'd2, 32'h0,        32'h0},
      '{1'b0, 2'd3, 32'h0,        32'h0},
      '{1'b1, 2'd1, 32'h12345678, 32'h0},
      '{1'b0, 2'd1, 32'h0,        32'h00345678},
      '{1'b1, 2'd0, 32'h00000005, 32'h0},
      '{1'b0, 2'd0, 32'h0,        IRQ_BUILD ? 32'h5 : 32'h1},
      '{1'b1, 2'd0, 32'h0,        32'h0},
      '{1'b0, 2'd0, 32'h0,        32'h0},
      '{1'b1, 2'd1, 32'h0,        32'h0},
      '{1'b0, 2'd1, 32'h0,        32'h0},
      '{1'b1, 2'd2, 32'hFFFFFFFF, 32'h0},
      '{1'b0, 2'd2, 32'h0,        32'h0},
      '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0},
      '{1'b0, 2'd3, 32'h0,        32'h0}
    };

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_done", {31'b0, bus_done}, 32'h0);
    check("rst_frame", {31'b0, pad_frame}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;

    // register table
    for (int i = 0; i < 16; i++) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // triggered poll with one new press
    base_frames = frames;
    pad_state = 16'hFF7F;
    bus(1'b1, 2'd0, 32'h6, rd);
    wait_frame(100, f1);
    wait_idle(3000);
`ifdef NESPAD_IRQ_EN
    check("irq_set", {31'b0, irq}, 32'h1);
`else
    check("irq_tied", {31'b0, irq}, 32'h0);
`endif
    bus(1'b0, 2'd2, 32'h0, rd);
    check("state_rd1", rd, 32'h00800080);
`ifdef NESPAD_IRQ_EN
    @(posedge clk); #1;
    check("irq_fall", {31'b0, irq}, 32'h0);
`endif
    bus(1'b0, 2'd2, 32'h0, rd);
    check("state_rd2", rd, 32'h00000080);
    bus(1'b0, 2'd3, 32'h0, rd);
    check("status_trig", rd, 32'h00000104);
    bus(1'b0, 2'd0, 32'h0, rd);
    check("ctrl_trig_clr", rd, IRQ_BUILD ? 32'h4 : 32'h0);
    check("trig_frames", frames - base_frames, 32'd1);
    bus(1'b1, 2'd0, 32'h0, rd);

    // timeout, with the clear write landing on the timeout cycle
    model_mute = 1'b1;
    bus(1'b1, 2'd0, 32'h2, rd);
    wait_frame(100, f1);
    wait_to(f1 + 2000);
    bus(1'b0, 2'd3, 32'h0, rd);
    check("to_busy", rd, 32'h00000105);
    wait_to(f1 + 2047);
    bus(1'b1, 2'd3, 32'h2, rd);
    bus(1'b0, 2'd3, 32'h0, rd);
    check("to_set_wins", rd, 32'h00000106);
    bus(1'b1, 2'd3, 32'h2, rd);
    bus(1'b0, 2'd3, 32'h0, rd);
    check("to_cleared", rd, 32'h00000104);
    model_mute = 1'b0;

    // STATE read in the capture cycle
    pad_state = 16'hFF77;
    bus(1'b1, 2'd0, 32'h2, rd);
    n = 0;
    while (!pad_done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", {31'b0, pad_done}, 32'h1);
    bus(1'b0, 2'd2, 32'h0, rd);
    check("capt_rd_old", rd, 32'h00000080);
    bus(1'b0, 2'd2, 32'h0, rd);
    check("capt_rd_new", rd, 32'h00080088);
    bus(1'b0, 2'd3, 32'h0, rd);
    check("status_capt", rd, 32'h00000204);

    // auto polling every 5000 cycles
    pad_state = 16'hFFFF;
    base_frames = frames;
    bus(1'b1, 2'd1, 32'd5000, rd);
    bus(1'b1, 2'd0, 32'h1, rd);
    wait_frame(6000, f1);
    wait_frame(6000, f2);
    wait_frame(6000, f3);
    check("gap1", f2 - f1, 32'd5000);
    check("gap2", f3 - f2, 32'd5000);
    wait_to(f3 + 1200);
    check("auto_frames", frames - base_frames, 32'd3);
    bus(1'b0, 2'd3, 32'h0, rd);
    check("status_auto", rd, 32'h00000504);
    bus(1'b1, 2'd0, 32'h0, rd);

    // interval shorter than a transaction
    base_frames = frames;
    base_poll = 5;
    mon_en = 1'b1;
    bus(1'b1, 2'd1, 32'd100, rd);
    bus(1'b1, 2'd0, 32'h1, rd);
    wait_to(cyc + 4000);
    bus(1'b1, 2'd0, 32'h0, rd);
    wait_to(cyc + 2500);
    mon_en = 1'b0;
    bus(1'b0, 2'd3, 32'h0, rd);
    check("short_idle", {31'b0, rd[0]}, 32'h0);
    check("short_frames_eq_polls", frames - base_frames, 32'(int'(rd[15:8]) - base_poll));
    check("short_min_frames", {31'b0, (frames - base_frames) >= 3}, 32'h1);
    check("short_overlap", overlap_err, 32'd0);

    // reset while waiting on the reader, with a read acknowledge in flight
    bus(1'b1, 2'd1, 32'd0, rd);
    bus(1'b1, 2'd0, 32'h2, rd);
    wait_frame(100, f1);
    repeat (500) @(posedge clk);
    #1;
    bus_start = 1'b1; bus_we = 1'b0; bus_addr = 2'd3;
    @(posedge clk); #1;
    bus_start = 1'b0;
    check("pre_rst_done", {31'b0, bus_done}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_done", {31'b0, bus_done}, 32'h0);
    check("arst_rdata", bus_rdata, 32'h0);
    check("arst_frame", {31'b0, pad_frame}, 32'h0);
    check("arst_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base_frames = frames;
    wait_to(cyc + 3000);
    check("post_rst_frames", frames - base_frames, 32'd0);
    bus(1'b0, 2'd3, 32'h0, rd);
    check("post_rst_status", rd, 32'h0);
    bus(1'b0, 2'd2, 32'h0, rd);
    check("post_rst_state", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
